// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory with 15 tagged transaction slots.
// Requests are granted combinationally to the lowest free tag, complete
// exactly MEM_LATENCY cycles later, and report tag/data from registers.

package dmem_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;
endpackage

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int MEM_WORDS   = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  BUS_COMMAND  proc2Dmem_command,
    input  logic [63:0] proc2Dmem_addr,
    input  logic [63:0] proc2Dmem_data,
    output logic [3:0]  Dmem2proc_response,
    output logic [63:0] Dmem2proc_data,
    output logic [3:0]  Dmem2proc_tag
);

    localparam int         NSLOT = 15;
    localparam int         IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [4:0] LAT   = 5'(MEM_LATENCY);

    // Memory array has no reset; contents survive reset by design.
    logic [63:0] mem_q [MEM_WORDS];

    logic [NSLOT-1:0] busy_q, busy_d;
    logic [4:0]       cnt_q  [NSLOT];
    logic [4:0]       cnt_d  [NSLOT];
    logic [63:0]      sdat_q [NSLOT];
    logic [63:0]      sdat_d [NSLOT];
    logic [3:0]       tag_q, tag_d;
    logic [63:0]      odat_q, odat_d;

    logic [IDX_W-1:0] idx;
    logic             is_req, is_store;
    logic [3:0]       grant;
    logic [63:0]      acc_data;
    logic             unused_addr_bits;

    // Upper address bits are dropped so out-of-range words alias.
    assign idx              = proc2Dmem_addr[3 +: IDX_W];
    assign unused_addr_bits = ^{proc2Dmem_addr[63:3+IDX_W], proc2Dmem_addr[2:0]};
    assign is_store         = (proc2Dmem_command == BUS_STORE);
    assign is_req           = (proc2Dmem_command == BUS_LOAD) || is_store;
    assign acc_data         = is_store ? proc2Dmem_data : mem_q[idx];

    // Grant the lowest free tag; a completing slot is still busy so it is skipped.
    always_comb begin
        grant = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!busy_q[i]) grant = 4'(i + 1);
        end
        if (reset || !is_req) grant = '0;
    end

    assign Dmem2proc_response = grant;

    // Slot countdowns, capture of accepted requests, and staging of the
    // completion that will be visible next cycle.
    always_comb begin
        busy_d = busy_q;
        tag_d  = '0;
        odat_d = '0;
        for (int i = 0; i < NSLOT; i++) begin
            cnt_d[i]  = cnt_q[i];
            sdat_d[i] = sdat_q[i];
            if (busy_q[i]) begin
                cnt_d[i] = cnt_q[i] - 5'd1;
                // count of 1 means completing this cycle: free at the edge
                if (cnt_q[i] == 5'd1) busy_d[i] = 1'b0;
                // count of 2 means completing next cycle: stage outputs now
                if (MEM_LATENCY > 1 && cnt_q[i] == 5'd2) begin
                    tag_d  = 4'(i + 1);
                    odat_d = sdat_q[i];
                end
            end
            if (grant == 4'(i + 1)) begin
                busy_d[i] = 1'b1;
                cnt_d[i]  = LAT;
                sdat_d[i] = acc_data;
                if (MEM_LATENCY == 1) begin
                    tag_d  = grant;
                    odat_d = acc_data;
                end
            end
        end
    end

    // Slot and output registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            tag_q  <= '0;
            odat_q <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                cnt_q[i]  <= '0;
                sdat_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
            odat_q <= odat_d;
            for (int i = 0; i < NSLOT; i++) begin
                cnt_q[i]  <= cnt_d[i];
                sdat_q[i] <= sdat_d[i];
            end
        end
    end

    // Accepted stores write the array; grant is already zero during reset.
    always_ff @(posedge clock) begin
        if (grant != 4'd0 && is_store) mem_q[idx] <= proc2Dmem_data;
    end

    assign Dmem2proc_tag  = tag_q;
    assign Dmem2proc_data = odat_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench: three responders (latency 4, 15, 20) share one stimulus
// stream and are each compared against a cycle-numbered reference model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int NI = 3;

    logic        clock;
    logic        rst;
    BUS_COMMAND  cmd;
    logic [63:0] addr, wd;
    logic [3:0]  resp [NI];
    logic [3:0]  tagv [NI];
    logic [63:0] rdat [NI];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model: per tag, busy flag, completion cycle and data
    bit          m_busy [NI][16];
    int          m_done [NI][16];
    logic [63:0] m_dat  [NI][16];
    logic [63:0] m_mem  [NI][1024];

    for (genvar g = 0; g < NI; g++) begin : gi
        dmem_responder #(
            .MEM_LATENCY(g == 0 ? 4 : (g == 1 ? 15 : 20)),
            .MEM_WORDS  (1024)
        ) dut (
            .clock             (clock),
            .reset             (rst),
            .proc2Dmem_command (cmd),
            .proc2Dmem_addr    (addr),
            .proc2Dmem_data    (wd),
            .Dmem2proc_response(resp[g]),
            .Dmem2proc_data    (rdat[g]),
            .Dmem2proc_tag     (tagv[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int lat(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 15 : 20);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NI; k++)
            for (int t = 0; t < 16; t++) m_busy[k][t] = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic step(input BUS_COMMAND c, input logic [63:0] a,
                        input logic [63:0] d, input logic r);
        @(posedge clock);
        #1;
        rst = r; cmd = c; addr = a; wd = d;
        @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            int          ct, er;
            logic [63:0] cd;
            logic [63:0] av;
            logic [9:0]  wi;
            ct = 0; cd = '0; er = 0;
            av = a;
            wi = av[12:3];
            if (!r) begin
                for (int t = 1; t < 16; t++)
                    if (m_busy[k][t] && m_done[k][t] == cyc) begin
                        ct = t; cd = m_dat[k][t];
                    end
                if (c != BUS_NONE)
                    for (int t = 15; t >= 1; t--)
                        if (!(m_busy[k][t] && m_done[k][t] >= cyc)) er = t;
            end
            chk($sformatf("resp[%0d] c%0d", k, cyc), 64'(resp[k]), 64'(er));
            chk($sformatf("tag[%0d] c%0d",  k, cyc), 64'(tagv[k]), 64'(ct));
            chk($sformatf("data[%0d] c%0d", k, cyc), rdat[k], cd);
            if (r) begin
                for (int t = 0; t < 16; t++) m_busy[k][t] = 1'b0;
            end else begin
                if (ct != 0) m_busy[k][ct] = 1'b0;
                if (er != 0) begin
                    m_busy[k][er] = 1'b1;
                    m_done[k][er] = cyc + lat(k);
                    m_dat[k][er]  = (c == BUS_STORE) ? d : m_mem[k][wi];
                    if (c == BUS_STORE) m_mem[k][wi] = d;
                end
            end
        end
        cyc++;
    endtask

    // Reset raised between edges: outputs must clear without a clock.
    task automatic mid_reset();
        @(posedge clock);
        #1;
        cmd = BUS_NONE;
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("async_tag[%0d]", k),  64'(tagv[k]), 64'd0);
            chk($sformatf("async_data[%0d]", k), rdat[k], 64'd0);
            chk($sformatf("async_resp[%0d]", k), 64'(resp[k]), 64'd0);
        end
        model_clear();
        cyc++;
    endtask

    function automatic logic [63:0] rnd_addr();
        logic [63:0] v;
        v = {$urandom, $urandom};
        v[12:3] = 10'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        rst = 1'b1; cmd = BUS_NONE; addr = '0; wd = '0;
        model_clear();
        for (int j = 0; j < 1024; j++) begin
            logic [63:0] v;
            v = (j == 16) ? 64'hDEAD : {$urandom, $urandom};
            gi[0].dut.mem_q[j] = v;
            gi[1].dut.mem_q[j] = v;
            gi[2].dut.mem_q[j] = v;
            for (int k = 0; k < NI; k++) m_mem[k][j] = v;
        end

        // reset state, including a request that must be refused
        step(BUS_LOAD, 64'h80, 64'd0, 1'b1);
        step(BUS_STORE, 64'h80, 64'h55, 1'b1);
        step(BUS_NONE, 64'h0, 64'd0, 1'b1);
        step(BUS_NONE, 64'h0, 64'd0, 1'b0);

        // load of preloaded word 0x10
        step(BUS_LOAD, 64'h80, 64'd0, 1'b0);
        repeat (6) step(BUS_NONE, 64'h0, 64'd0, 1'b0);

        // store then load of the same word in back-to-back cycles
        step(BUS_STORE, 64'h40, 64'h1234, 1'b0);
        step(BUS_LOAD,  64'h40, 64'd0,    1'b0);
        repeat (25) step(BUS_NONE, 64'h0, 64'd0, 1'b0);

        // continuous loads: saturates slots and exercises tag reuse
        repeat (45) step(BUS_LOAD, rnd_addr(), 64'd0, 1'b0);
        repeat (25) step(BUS_NONE, 64'h0, 64'd0, 1'b0);

        // idle
        repeat (10) step(BUS_NONE, rnd_addr(), {$urandom, $urandom}, 1'b0);

        // random mix with aliasing upper address bits
        repeat (400) begin
            int          p;
            BUS_COMMAND  c;
            p = $urandom_range(0, 9);
            c = (p < 2) ? BUS_NONE : ((p < 6) ? BUS_LOAD : BUS_STORE);
            step(c, rnd_addr(), {$urandom, $urandom}, 1'b0);
        end
        repeat (25) step(BUS_NONE, 64'h0, 64'd0, 1'b0);

        // reset with transactions outstanding
        step(BUS_LOAD, 64'h80, 64'd0, 1'b0);
        step(BUS_LOAD, 64'h40, 64'd0, 1'b0);
        mid_reset();
        step(BUS_NONE, 64'h0, 64'd0, 1'b1);
        step(BUS_LOAD, 64'h0, 64'd0, 1'b1);
        step(BUS_NONE, 64'h0, 64'd0, 1'b0);
        step(BUS_LOAD, 64'h80, 64'd0, 1'b0);
        repeat (25) step(BUS_NONE, 64'h0, 64'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
